clock_phase_ctrl: RTL

//   Parametrised per-domain clock-enable generator for the processor top level.
//   - Divides the single master clock into a repeating frame of DIV cycles.
//   - Issues a one-cycle enable per channel (imem, dmem, regfile, processor, ...) at a programmable phase.
//   - Adds a debug halt / single-step handshake so benches can freeze the core on frame boundaries.

---
 rtl/clock_phase_ctrl_pkg.sv | 23 ++
 rtl/clock_phase_ctrl_if.sv | 27 ++
 rtl/clock_phase_ctrl_phase_counter.sv | 38 +++
 rtl/clock_phase_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/clock_phase_ctrl_pkg.sv
// Shared types and constants for the clock-phase controller.
package clk_ctrl_pkg;

  // Controller modes: free running, halt pending at frame end, frozen, single frame.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2,
    STEP    = 2'd3
  } state_e;

  // Channel index assignments used by the processor top level.
  localparam int CH_IMEM    = 0;
  localparam int CH_DMEM    = 1;
  localparam int CH_REGFILE = 2;
  localparam int CH_PROC    = 3;

  // A frame is in progress in every mode except HALTED.
  function automatic logic is_active(state_e s);
    return (s != HALTED);
  endfunction

endpackage

// File: rtl/clock_phase_ctrl_if.sv
// Control/status bundle between the clock-phase controller and its user.
interface clock_phase_ctrl_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 2,
  parameter int FRAME_W = 16
);
  logic               halt_req;
  logic               step_req;
  logic [NUM_CH-1:0]  ch_en;
  logic               frame_start;
  logic [CNT_W-1:0]   phase;
  logic               halted;
  logic               step_done;
  logic [FRAME_W-1:0] frame_cnt;

  // Requester side: drives halt/step, observes enables and status.
  modport master (
    output halt_req, step_req,
    input  ch_en, frame_start, phase, halted, step_done, frame_cnt
  );

  // Controller side.
  modport slave (
    input  halt_req, step_req,
    output ch_en, frame_start, phase, halted, step_done, frame_cnt
  );
endinterface

// File: rtl/clock_phase_ctrl_phase_counter.sv
// Modulo-DIV phase counter with count enable and end-of-frame wrap pulse.
module phase_counter #(
  parameter int DIV   = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance while enabled, returning to zero after the last phase of a frame.
  always_comb begin
    wrap_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Phase register; reset puts the frame back at phase 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clock_phase_ctrl.sv
// Per-domain clock-enable generator with debug halt / single-step control.
module clock_phase_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DIV           = 4,
  localparam int CNT_W        = (DIV > 1) ? $clog2(DIV) : 1,
  parameter logic [NUM_CH*CNT_W-1:0] PHASE = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter int FRAME_W       = 16,
  parameter bit START_HALTED  = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  clock_phase_ctrl_if.slave  bus
);

  // Reject unusable frame lengths and phases outside the frame.
  if (DIV < 2) begin : g_bad_div
    $error("clock_phase_ctrl: DIV must be at least 2");
  end
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_phase_chk
    if (int'(PHASE[gi*CNT_W +: CNT_W]) >= DIV) begin : g_bad_phase
      $error("clock_phase_ctrl: channel phase must be below DIV");
    end
  end

  localparam state_e RESET_STATE = START_HALTED ? HALTED : RUN;

  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic               step_done_q;
  logic               step_done_d;
  logic [CNT_W-1:0]   cnt;
  logic               wrap;
  logic               active;

  assign active = is_active(state_q);

  // The counter only runs during an active frame, so it sits at 0 while halted.
  phase_counter #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (active),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // Mode register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode transitions; halts and steps only ever end on a frame boundary (wrap).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.halt_req) begin
          state_d = wrap ? HALTED : HALTING;
        end
      end
      HALTING: begin
        if (wrap) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!bus.halt_req) begin
          state_d = RUN;
        end else if (bus.step_req) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (wrap) begin
          state_d = HALTED;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Enable and status decode, purely from registered state and phase.
  always_comb begin
    bus.ch_en       = '0;
    bus.frame_start = active && (cnt == '0);
    bus.halted      = (state_q == HALTED);
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_en[i] = active && (cnt == PHASE[i*CNT_W +: CNT_W]);
    end
  end

  // Frame bookkeeping: count completed frames, flag the end of a step frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q + FRAME_W'(wrap);
    step_done_d = (state_q == STEP) && wrap;
  end

  // Frame counter and step-done pulse registers; reset drops any pending pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      step_done_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.phase     = cnt;
  assign bus.step_done = step_done_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
